vec_mac_feeder: RTL and testbench

//  Streams matrix-vector operands to vec_mac and collects its per-row dot products.

---
 rtl/vec_mac_feeder.sv | 226 ++++++++++++++++++++++
 tb/tb_vec_mac_feeder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mac_feeder.sv
// rtl/vec_mac_feeder.sv - streams matrix rows and a shared vector into vec_mac, returns per-row dot products
//
// Purpose
//   Takes one command (A base, B base, row_size, num_rows). For every row it pulses mac_start, reads
//   nch = max(1, ceil(row_size/CHUNK)) chunks of A and B from two 1-cycle-latency RAMs and drives them
//   back-to-back to vec_mac. It then captures mac_result and offers it on a valid/ready result port.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_base_a, cmd_base_b, cmd_row_size, cmd_num_rows
//   ram_a_addr/ram_a_rdata     A operand RAM (chunk address out, chunk data back one cycle later)
//   ram_b_addr/ram_b_rdata     B operand RAM, same timing
//   mac_start, mac_row_size    vec_mac control; row size held for the whole row
//   mac_vec_a, mac_vec_b       one CHUNK-element slice per cycle, zero outside streaming
//   mac_result, mac_done       vec_mac result, done flag during the last slice cycle
//   res_valid/res_ready        result handshake; res_data, res_last
//   err                        sticky: mac_done not coincident with the last slice

module vec_mac_feeder #(
   parameter int WIDTH    = 16,
   parameter int N        = 8,
   parameter int NUM_MACS = 2,
   parameter int ADDR_W   = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [ADDR_W-1:0]                 cmd_base_a,
   input  logic [ADDR_W-1:0]                 cmd_base_b,
   input  logic [31:0]                       cmd_row_size,
   input  logic [15:0]                       cmd_num_rows,
   output logic [ADDR_W-1:0]                 ram_a_addr,
   input  logic [NUM_MACS*N*WIDTH-1:0]       ram_a_rdata,
   output logic [ADDR_W-1:0]                 ram_b_addr,
   input  logic [NUM_MACS*N*WIDTH-1:0]       ram_b_rdata,
   output logic                              mac_start,
   output logic [31:0]                       mac_row_size,
   output logic [NUM_MACS*N*WIDTH-1:0]       mac_vec_a,
   output logic [NUM_MACS*N*WIDTH-1:0]       mac_vec_b,
   input  logic signed [2*WIDTH-1:0]         mac_result,
   input  logic                              mac_done,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic signed [2*WIDTH-1:0]         res_data,
   output logic                              res_last,
   output logic                              err
);

   localparam int CHUNK = NUM_MACS * N;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_STREAM,
      S_OUT
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         row_base_q, row_base_d;   // chunk address of the current A row
   logic [ADDR_W-1:0]         base_b_q, base_b_d;
   logic [31:0]               row_size_q, row_size_d;
   logic [15:0]               num_rows_q, num_rows_d;
   logic [31:0]               nch_q, nch_d;
   logic [15:0]               row_q, row_d;
   logic [31:0]               chunk_q, chunk_d;         // index of the chunk whose data is on the RAM outputs
   logic [CHUNK-1:0]          mask_q, mask_d;           // element-valid mask, registered alongside RAM data
   logic signed [2*WIDTH-1:0] res_data_q, res_data_d;
   logic                      err_q, err_d;

   logic [31:0]               chunk_nxt;
   logic                      last_slice;

   // Chunks per row; a zero-length row still needs one (all-zero) slice.
   function automatic logic [31:0] calc_nch(input logic [31:0] rs);
      logic [31:0] q;
      q = rs / 32'(CHUNK);
      if ((rs % 32'(CHUNK)) != 32'd0) begin
         q = q + 32'd1;
      end
      if (q == 32'd0) begin
         q = 32'd1;
      end
      return q;
   endfunction

   // Element e of chunk idx is live when its global index is below row_size.
   function automatic logic [CHUNK-1:0] calc_mask(input logic [31:0] idx, input logic [31:0] rs);
      logic [CHUNK-1:0] m;
      logic [32:0]      first;
      first = {1'b0, idx} * 33'(CHUNK);
      for (int e = 0; e < CHUNK; e++) begin
         m[e] = (first + 33'(e)) < {1'b0, rs};
      end
      return m;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         row_base_q <= '0;
         base_b_q   <= '0;
         row_size_q <= '0;
         num_rows_q <= '0;
         nch_q      <= '0;
         row_q      <= '0;
         chunk_q    <= '0;
         mask_q     <= '0;
         res_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_base_q <= row_base_d;
         base_b_q   <= base_b_d;
         row_size_q <= row_size_d;
         num_rows_q <= num_rows_d;
         nch_q      <= nch_d;
         row_q      <= row_d;
         chunk_q    <= chunk_d;
         mask_q     <= mask_d;
         res_data_q <= res_data_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      row_base_d = row_base_q;
      base_b_d   = base_b_q;
      row_size_d = row_size_q;
      num_rows_d = num_rows_q;
      nch_d      = nch_q;
      row_d      = row_q;
      chunk_d    = chunk_q;
      mask_d     = mask_q;
      res_data_d = res_data_q;
      err_d      = err_q;

      cmd_ready  = 1'b0;
      mac_start  = 1'b0;
      ram_a_addr = '0;
      ram_b_addr = '0;
      mac_vec_a  = '0;
      mac_vec_b  = '0;
      res_valid  = 1'b0;
      res_last   = 1'b0;

      chunk_nxt  = chunk_q + 32'd1;
      last_slice = (chunk_q == (nch_q - 32'd1));

      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               row_base_d = cmd_base_a;
               base_b_d   = cmd_base_b;
               row_size_d = cmd_row_size;
               num_rows_d = cmd_num_rows;
               nch_d      = calc_nch(cmd_row_size);
               row_d      = '0;
               if (cmd_num_rows != 16'd0) begin
                  state_d = S_START;
               end
            end
         end

         S_START: begin
            mac_start  = 1'b1;
            ram_a_addr = row_base_q;
            ram_b_addr = base_b_q;
            chunk_d    = '0;
            mask_d     = calc_mask(32'd0, row_size_q);
            state_d    = S_STREAM;
         end

         S_STREAM: begin
            for (int e = 0; e < CHUNK; e++) begin
               if (mask_q[e]) begin
                  mac_vec_a[e*WIDTH +: WIDTH] = ram_a_rdata[e*WIDTH +: WIDTH];
                  mac_vec_b[e*WIDTH +: WIDTH] = ram_b_rdata[e*WIDTH +: WIDTH];
               end
            end
            if (last_slice) begin
               // Capture regardless of mac_done so the row still completes; a missing done is flagged.
               res_data_d = mac_result;
               if (!mac_done) begin
                  err_d = 1'b1;
               end
               state_d = S_OUT;
            end else begin
               // Prefetch the next chunk so slices run back-to-back.
               ram_a_addr = row_base_q + chunk_nxt[ADDR_W-1:0];
               ram_b_addr = base_b_q + chunk_nxt[ADDR_W-1:0];
               mask_d     = calc_mask(chunk_nxt, row_size_q);
               chunk_d    = chunk_nxt;
               if (mac_done) begin
                  err_d = 1'b1;
               end
            end
         end

         S_OUT: begin
            res_valid = 1'b1;
            res_last  = (row_q == (num_rows_q - 16'd1));
            if (res_ready) begin
               if (res_last) begin
                  state_d = S_IDLE;
               end else begin
                  row_d      = row_q + 16'd1;
                  row_base_d = row_base_q + nch_q[ADDR_W-1:0];
                  state_d    = S_START;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mac_row_size = row_size_q;
   assign res_data     = res_data_q;
   assign err          = err_q;

endmodule

// File: tb/tb_vec_mac_feeder.sv
// tb/tb_vec_mac_feeder.sv - randomized self-checking bench for vec_mac_feeder with RAM and vec_mac stubs

module tb_vec_mac_feeder;

   localparam int WIDTH    = 16;
   localparam int N        = 8;
   localparam int NUM_MACS = 2;
   localparam int ADDR_W   = 16;
   localparam int CHUNK    = NUM_MACS * N;
   localparam int DW       = CHUNK * WIDTH;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     cmd_valid = 1'b0;
   logic                     cmd_ready;
   logic [ADDR_W-1:0]        cmd_base_a = '0;
   logic [ADDR_W-1:0]        cmd_base_b = '0;
   logic [31:0]              cmd_row_size = '0;
   logic [15:0]              cmd_num_rows = '0;
   logic [ADDR_W-1:0]        ram_a_addr, ram_b_addr;
   logic [DW-1:0]            ram_a_rdata = '0;
   logic [DW-1:0]            ram_b_rdata = '0;
   logic                     mac_start;
   logic [31:0]              mac_row_size;
   logic [DW-1:0]            mac_vec_a, mac_vec_b;
   logic signed [2*WIDTH-1:0] mac_result;
   logic                     mac_done;
   logic                     res_valid;
   logic                     res_ready = 1'b0;
   logic signed [2*WIDTH-1:0] res_data;
   logic                     res_last;
   logic                     err;

   int checks = 0;
   int errors = 0;

   vec_mac_feeder #(.WIDTH(WIDTH), .N(N), .NUM_MACS(NUM_MACS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b),
      .cmd_row_size(cmd_row_size), .cmd_num_rows(cmd_num_rows),
      .ram_a_addr(ram_a_addr), .ram_a_rdata(ram_a_rdata),
      .ram_b_addr(ram_b_addr), .ram_b_rdata(ram_b_rdata),
      .mac_start(mac_start), .mac_row_size(mac_row_size),
      .mac_vec_a(mac_vec_a), .mac_vec_b(mac_vec_b),
      .mac_result(mac_result), .mac_done(mac_done),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_last(res_last), .err(err)
   );

   always #5 clk = ~clk;

   // Operand RAMs: 256 chunks each, indexed by the low address byte, 1-cycle read latency.
   logic [DW-1:0] mem_a [256];
   logic [DW-1:0] mem_b [256];

   always @(posedge clk) begin
      ram_a_rdata <= mem_a[ram_a_addr[7:0]];
      ram_b_rdata <= mem_b[ram_b_addr[7:0]];
   end

   // vec_mac stub: accumulates the slice dot products after mac_start and raises done on the last slice.
   // done_mode: 0 normal, 1 done dropped, 2 done also raised on the first of several slices.
   int                    done_mode = 0;
   logic                  stub_active;
   int                    stub_cnt;
   logic signed [31:0]    stub_acc;
   int                    stub_nch;
   int                    ms_cnt;

   function automatic logic signed [31:0] slice_dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [31:0] s;
      logic signed [15:0] x, y;
      s = 0;
      for (int e = 0; e < CHUNK; e++) begin
         x = a[e*WIDTH +: WIDTH];
         y = b[e*WIDTH +: WIDTH];
         s = s + x * y;
      end
      return s;
   endfunction

   always_comb begin
      stub_nch = (int'(mac_row_size) + CHUNK - 1) / CHUNK;
      if (stub_nch == 0) stub_nch = 1;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         stub_active <= 1'b0;
         stub_cnt    <= 0;
         stub_acc    <= 0;
         ms_cnt      <= 0;
      end else if (mac_start) begin
         stub_active <= 1'b1;
         stub_cnt    <= 0;
         stub_acc    <= 0;
         ms_cnt      <= ms_cnt + 1;
      end else if (stub_active) begin
         stub_acc <= stub_acc + slice_dot(mac_vec_a, mac_vec_b);
         stub_cnt <= stub_cnt + 1;
         if (stub_cnt == stub_nch - 1) stub_active <= 1'b0;
      end
   end

   assign mac_result = stub_acc + slice_dot(mac_vec_a, mac_vec_b);
   assign mac_done   = stub_active &&
                       (((stub_cnt == stub_nch - 1) && done_mode != 1) ||
                        (done_mode == 2 && stub_cnt == 0 && stub_nch > 1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference: dot product of row r straight from the element definition.
   function automatic logic signed [31:0] model_row(input logic [15:0] ba, input logic [15:0] bb,
                                                    input int rs, input int r);
      longint             sum;
      int                 nch;
      logic [15:0]        aa, ab;
      logic signed [15:0] x, y;
      logic [63:0]        s64;
      nch = (rs + CHUNK - 1) / CHUNK;
      if (nch == 0) nch = 1;
      sum = 0;
      for (int i = 0; i < rs; i++) begin
         aa  = 16'(int'(ba) + r * nch + i / CHUNK);
         ab  = 16'(int'(bb) + i / CHUNK);
         x   = mem_a[aa[7:0]][(i % CHUNK)*WIDTH +: WIDTH];
         y   = mem_b[ab[7:0]][(i % CHUNK)*WIDTH +: WIDTH];
         sum = sum + longint'(x) * longint'(y);
      end
      s64 = 64'(sum);
      return s64[31:0];
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < 256; i++) begin
         for (int w = 0; w < DW/32; w++) begin
            mem_a[i][w*32 +: 32] = $urandom;
            mem_b[i][w*32 +: 32] = $urandom;
         end
      end
   endtask

   task automatic set_chunk(input bit is_b, input logic [15:0] addr, input logic [15:0] v);
      for (int e = 0; e < CHUNK; e++) begin
         if (is_b) mem_b[addr[7:0]][e*WIDTH +: WIDTH] = v;
         else      mem_a[addr[7:0]][e*WIDTH +: WIDTH] = v;
      end
   endtask

   logic signed [31:0] last_res;

   task automatic run_cmd(input logic [15:0] ba, input logic [15:0] bb, input int rs, input int nr,
                          input int hold, input bit exp_err);
      int                 lat;
      int                 nch;
      int                 ms0;
      int                 ms_hold;
      logic signed [31:0] exp;
      nch = (rs + CHUNK - 1) / CHUNK;
      if (nch == 0) nch = 1;
      @(negedge clk);
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      ms0          = ms_cnt;
      cmd_valid    = 1'b1;
      cmd_base_a   = ba;
      cmd_base_b   = bb;
      cmd_row_size = 32'(rs);
      cmd_num_rows = 16'(nr);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat       = 1;
      if (nr == 0) begin
         chk("nr0_cmd_ready", 64'(cmd_ready), 64'd1);
         repeat (3) @(negedge clk);
         chk("nr0_no_valid", 64'(res_valid), 64'd0);
         chk("nr0_no_start", 64'(ms_cnt - ms0), 64'd0);
         return;
      end
      chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      for (int r = 0; r < nr; r++) begin
         while (!res_valid && lat < 300) begin
            @(negedge clk);
            lat++;
         end
         chk("res_valid_timeout", 64'(res_valid), 64'd1);
         if (!res_valid) return;
         if (r == 0) chk("first_latency", 64'(lat), 64'(nch + 2));
         exp = model_row(ba, bb, rs, r);
         chk("res_data", 64'(res_data), 64'(exp));
         chk("res_last", 64'(res_last), 64'(r == nr - 1));
         last_res = res_data;
         if (hold > 0) begin
            ms_hold = ms_cnt;
            repeat (hold) @(negedge clk);
            chk("hold_data", 64'(res_data), 64'(exp));
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_no_start", 64'(ms_cnt - ms_hold), 64'd0);
         end
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         lat       = 0;
      end
      chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
      chk("start_count", 64'(ms_cnt - ms0), 64'(nr));
      chk("err_flag", 64'(err), 64'(exp_err));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      chk({tag, "_mac_start"}, 64'(mac_start), 64'd0);
      chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
      chk({tag, "_res_last"},  64'(res_last), 64'd0);
      chk({tag, "_err"},       64'(err), 64'd0);
      chk({tag, "_res_data"},  64'(res_data), 64'd0);
      chk({tag, "_addr_a"},    64'(ram_a_addr), 64'd0);
      chk({tag, "_vec_a"},     64'(|mac_vec_a), 64'd0);
   endtask

   initial begin
      fill_rand();
      #12;
      check_reset_outputs("rst0");
      @(negedge clk);
      rst = 1'b1;

      // Single chunk: 16 x (2*3)
      set_chunk(1'b0, 16'd10, 16'd2);
      set_chunk(1'b1, 16'd50, 16'd3);
      run_cmd(16'd10, 16'd50, 16, 1, 0, 1'b0);
      chk("s1_literal", 64'(last_res), 64'd96);

      // Three chunks with an 8-element tail; RAM holds ones beyond row_size too
      for (int c = 0; c < 3; c++) begin
         set_chunk(1'b0, 16'(20 + c), 16'd1);
         set_chunk(1'b1, 16'(60 + c), 16'd1);
      end
      run_cmd(16'd20, 16'd60, 40, 1, 0, 1'b0);
      chk("s2_literal", 64'(last_res), 64'd40);

      // Three rows of two chunks, each row a different constant, with a held result
      for (int c = 0; c < 6; c++) set_chunk(1'b0, 16'(100 + c), 16'(c / 2 + 1));
      set_chunk(1'b1, 16'd70, 16'd1);
      set_chunk(1'b1, 16'd71, 16'd1);
      run_cmd(16'd100, 16'd70, 32, 3, 5, 1'b0);
      chk("s3_literal", 64'(last_res), 64'd96);

      // Zero-length row and zero-row command
      run_cmd(16'd5, 16'd6, 0, 1, 0, 1'b0);
      chk("rs0_literal", 64'(last_res), 64'd0);
      run_cmd(16'd5, 16'd6, 20, 0, 0, 1'b0);

      // Row address wrap across the top of the address space
      run_cmd(16'hFFFE, 16'h00F0, 33, 2, 1, 1'b0);

      // Randomized commands
      for (int t = 0; t < 14; t++) begin
         fill_rand();
         run_cmd(16'($urandom), 16'($urandom), int'($urandom_range(0, 70)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      end

      // Early done on a multi-slice row sets err; err stays set afterwards
      done_mode = 2;
      run_cmd(16'd30, 16'd40, 48, 1, 0, 1'b1);
      done_mode = 0;
      run_cmd(16'd31, 16'd41, 17, 1, 0, 1'b1);

      // Reset mid-stream clears everything including err
      @(negedge clk);
      cmd_valid    = 1'b1;
      cmd_base_a   = 16'd0;
      cmd_base_b   = 16'd8;
      cmd_row_size = 32'd64;
      cmd_num_rows = 16'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_stream_vec_live", 64'(mac_start), 64'd0);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      rst = 1'b1;
      fill_rand();
      run_cmd(16'd3, 16'd9, 50, 2, 2, 1'b0);

      // Dropped done sets err
      done_mode = 1;
      run_cmd(16'd12, 16'd13, 16, 1, 0, 1'b1);
      done_mode = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got 1 exp 0");
      $fatal(1, "timeout");
   end

endmodule
